seg_display_ctrl: RTL and testbench
===================================

// Module: seg_display_ctrl
// PURPOSE
//  Parametrised multi-digit seven-segment display controller for the HEX0..HEXn bank.
//  Supersedes the per-digit hex drivers and the hand-built sign/hundreds wiring.
//  Accepts a binary word via valid/ready and shows it in hex or signed decimal.
//  Decimal uses a sequential double-dabble; adds leading-zero blanking, auto-placed minus sign, blink.
// PARAMETERS
//  NUM_DIGITS  6           number of seven-segment digits driven
//  DATA_W      16          width of load_data (>=4)
//  BLINK_DIV   25_000_000  Clk cycles per blink half-period (>=2)
//  ACTIVE_LOW  1           1: segment on = 0 (DE10-Lite); 0: segment on = 1
// PORTS
//  Clk          in   1               system clock (50 MHz)
//  Reset_n      in   1               asynchronous, active-low reset
//  load_valid   in   1               load_data/mode/load_signed valid
//  load_ready   out  1               controller idle, can accept load
//  load_data    in   DATA_W          value to display
//  load_signed  in   1               decimal mode: treat load_data as two's complement
//  mode         in   1               0 = hex, 1 = decimal
//  blank_lz     in   1               1 = blank leading zeros (sampled at handshake)
//  blink_en     in   1               1 = whole display blinks at BLINK_DIV rate (live input)
//  seg_out      out  8*NUM_DIGITS    digit i = seg_out[8i+7:8i], bits {dp,g,f,e,d,c,b,a}
//  busy         out  1               conversion in progress (= ~load_ready)
//  overflow     out  1               last committed value did not fit
// BEHAVIOUR
//  Reset (async, Reset_n=0):
//    state IDLE; load_ready=1; busy=0; overflow=0; blink counter=0; blink phase=on.
//    Display reg holds "0" in digit 0, other digits blank.
//  Handshake: transfer on rising edge with load_valid & load_ready.
//    load_valid while busy is ignored, not queued.
//  FSM IDLE -> CONV -> COMMIT -> IDLE. Hex mode skips CONV (IDLE -> COMMIT).
//    Handshake edge k captures inputs.
//    Hex: seg_out updates at edge k+1.
//    Decimal: CONV is DATA_W cycles with one shift/add-3 per cycle; seg_out updates at edge k+DATA_W+1.
//    load_ready returns 1 on the same edge seg_out updates.
//  Decimal arithmetic:
//    If load_signed & load_data[DATA_W-1], mag = -load_data (DATA_W+1 bits, so min-int is exact) and neg=1.
//    BCD register is 4*NUM_DIGITS bits.
//  Hex: nibble i -> digit i. Digits >= ceil(DATA_W/4) are blank. neg is always 0.
//  Blanking:
//    blank_lz=1: digits above the most significant nonzero digit are blank; digit 0 is always shown.
//    blank_lz=0: all digits are shown.
//  Sign:
//    If neg, the minus (g only) goes in the first blank digit left of the most significant shown digit.
//    With blank_lz=0 it goes in digit NUM_DIGITS-1, which must then be a leading zero.
//  Overflow (overflow=1, all digits show '-'):
//    Decimal: nonzero BCD carry-out, or neg with no free digit.
//    Hex: nonzero nibbles beyond NUM_DIGITS.
//    overflow clears on the next non-overflowing commit.
//  dp is always off. Polarity is applied per ACTIVE_LOW at the output only.
//  Blink:
//    Counter runs only while blink_en=1 and wraps at BLINK_DIV-1, toggling the phase.
//    Off phase forces all segments off.
//    blink_en=0 clears the counter, sets phase to on, and takes effect the next cycle.
//  All outputs are registered. A reset mid-CONV aborts; the display returns to its reset value.
// STRUCTURE
//  seven_seg_pkg:
//    SEG_* glyph constants (0-F, blank, minus).
//    state_t enum {IDLE,CONV,COMMIT}.
//    function digit_to_seg(logic [3:0]).
//  Sub-module seg_digit_enc: combinational nibble+blank+minus -> 7 segments, instantiated NUM_DIGITS times.
//  Double-dabble datapath and FSM stay in this module.
// TESTING
//  Hex 16'hBEEF, blank_lz=0, N=6 -> digits 0..3 = F,E,E,B; digits 4,5 blank; seg_out valid 1 cycle after handshake.
//  Decimal unsigned 16'd65535 -> "65535", digit 5 blank; update exactly DATA_W+1=17 edges after handshake; load_ready low 17 cycles.
//  Decimal signed 16'h8000, blank_lz=1 -> "-32768" with minus in digit 5. 16'hFFF6 -> minus in digit 2, "10" in digits 1..0, digits 5..3 blank.
//  NUM_DIGITS=4, decimal 16'd12345 -> overflow=1, all four digits '-'. Then load 16'd7 -> overflow=0, display "7".
//  load_valid held during CONV -> second value ignored, first value displayed. Reset_n pulsed mid-CONV -> reset display, load_ready=1.
//  BLINK_DIV=4, blink_en=1 -> all segments off for 4 cycles, on for 4 cycles, repeating. blink_en=0 -> steady on next cycle.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared glyphs, controller states and the hex-digit glyph lookup for the seven-segment bank.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;

  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = SEG_0;
      4'h1:    s = SEG_1;
      4'h2:    s = SEG_2;
      4'h3:    s = SEG_3;
      4'h4:    s = SEG_4;
      4'h5:    s = SEG_5;
      4'h6:    s = SEG_6;
      4'h7:    s = SEG_7;
      4'h8:    s = SEG_8;
      4'h9:    s = SEG_9;
      4'hA:    s = SEG_A;
      4'hB:    s = SEG_B;
      4'hC:    s = SEG_C;
      4'hD:    s = SEG_D;
      4'hE:    s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_digit_enc.sv
// One digit: nibble plus blank/minus overrides to active-high {dp,g,f,e,d,c,b,a}.
module seg_digit_enc
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  input  logic       minus_i,
  output logic [7:0] seg_o
);

  // Minus wins over blank so sign and overflow dashes can land in otherwise-blank digits.
  always_comb begin
    seg_o = 8'h00;
    if (minus_i) begin
      seg_o[6:0] = SEG_MINUS;
    end else if (!blank_i) begin
      seg_o[6:0] = digit_to_seg(nibble_i);
    end
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// Multi-digit seven-segment controller: hex or signed decimal (sequential double-dabble),
// leading-zero blanking, auto-placed minus sign, overflow dashes and whole-display blink.
module seg_display_ctrl
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned BLINK_DIV  = 25_000_000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [DATA_W-1:0]       load_data,
  input  logic                    load_signed,
  input  logic                    mode,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic [8*NUM_DIGITS-1:0] seg_out,
  output logic                    busy,
  output logic                    overflow
);

  localparam int unsigned BCD_W      = 4 * NUM_DIGITS;
  localparam int unsigned DISP_W     = 8 * NUM_DIGITS;
  localparam int unsigned HEX_DIGITS = (DATA_W + 3) / 4;
  localparam int unsigned PAD_DIGITS = (HEX_DIGITS > NUM_DIGITS) ? HEX_DIGITS : NUM_DIGITS;
  localparam int unsigned CNT_W      = $clog2(DATA_W + 1);
  localparam int unsigned BCNT_W     = $clog2(BLINK_DIV);
  localparam logic [DISP_W-1:0] DISP_RST = DISP_W'({1'b0, SEG_0});

  state_t                  state_q;
  logic                    ready_q, busy_q, ovf_q;
  logic                    hex_q, neg_q, blz_q, carry_q;
  logic [DATA_W-1:0]       mag_q;
  logic [BCD_W-1:0]        bcd_q, bcd_adj;
  logic [CNT_W-1:0]        cnt_q;
  logic [DISP_W-1:0]       disp_q, disp_d, commit_disp;
  logic                    commit_ovf;
  logic [BCNT_W-1:0]       bcnt_q, bcnt_d;
  logic                    phase_q, phase_d;
  logic [DISP_W-1:0]       seg_q, seg_raw;
  logic                    load_neg;
  logic [4*PAD_DIGITS-1:0] hex_pad;
  logic [3:0]              dig_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   dig_present, dig_blank, dig_minus;
  int unsigned             msd, sign_pos;

  assign load_neg = mode & load_signed & load_data[DATA_W-1];

  // Add-3 correction on every BCD digit >= 5 before the next shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Zero-extend the captured word so every hex digit slice stays in range.
  always_comb begin
    hex_pad = '0;
    hex_pad[DATA_W-1:0] = mag_q;
  end

  // Commit-time decode: digit values, blanking, sign placement and overflow.
  always_comb begin
    dig_present = '0;
    commit_ovf  = 1'b0;
    msd         = 0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      dig_nib[i]     = hex_q ? hex_pad[4*i +: 4] : bcd_q[4*i +: 4];
      dig_present[i] = hex_q ? (i < HEX_DIGITS) : 1'b1;
    end
    if (hex_q) begin
      for (int unsigned j = NUM_DIGITS; j < PAD_DIGITS; j++) begin
        if (hex_pad[4*j +: 4] != 4'h0) commit_ovf = 1'b1;
      end
    end else begin
      commit_ovf = carry_q;
    end
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (dig_present[i] && (dig_nib[i] != 4'h0)) msd = i;
    end
    // The sign needs a free digit above the most significant one in both blanking modes.
    if (neg_q && (msd >= NUM_DIGITS - 1)) commit_ovf = 1'b1;
    sign_pos = blz_q ? (msd + 1) : (NUM_DIGITS - 1);
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      dig_blank[i] = !dig_present[i] || (blz_q && (i > msd));
      dig_minus[i] = commit_ovf || (neg_q && (i == sign_pos));
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    seg_digit_enc u_enc (
      .nibble_i (dig_nib[g]),
      .blank_i  (dig_blank[g]),
      .minus_i  (dig_minus[g]),
      .seg_o    (commit_disp[8*g +: 8])
    );
  end

  // Display register only changes on the commit cycle.
  always_comb begin
    disp_d = (state_q == COMMIT) ? commit_disp : disp_q;
  end

  // Control FSM with the double-dabble datapath: capture, shift DATA_W times, commit.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      hex_q   <= 1'b0;
      neg_q   <= 1'b0;
      blz_q   <= 1'b0;
      carry_q <= 1'b0;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= DISP_RST;
    end else begin
      disp_q <= disp_d;
      unique case (state_q)
        IDLE: begin
          if (load_valid && ready_q) begin
            hex_q   <= ~mode;
            neg_q   <= load_neg;
            blz_q   <= blank_lz;
            // Negating min-int wraps to itself, which is its exact unsigned magnitude.
            mag_q   <= load_neg ? (-load_data) : load_data;
            bcd_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= mode ? CONV : COMMIT;
          end
        end
        CONV: begin
          bcd_q   <= {bcd_adj[BCD_W-2:0], mag_q[DATA_W-1]};
          mag_q   <= {mag_q[DATA_W-2:0], 1'b0};
          // Any bit leaving the top digit means the value needs more digits than we have.
          carry_q <= carry_q | bcd_adj[BCD_W-1];
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) state_q <= COMMIT;
        end
        COMMIT: begin
          ovf_q   <= commit_ovf;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Blink next-state: free-running only while enabled, otherwise parked in the on phase.
  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (!blink_en) begin
      bcnt_d  = '0;
      phase_d = 1'b1;
    end else if (bcnt_q == BCNT_W'(BLINK_DIV - 1)) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end else begin
      bcnt_d = bcnt_q + BCNT_W'(1);
    end
  end

  // Blink counter and phase.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bcnt_q  <= '0;
      phase_q <= 1'b1;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  // Output register: blink gating then pad polarity.
  always_comb begin
    seg_raw = phase_d ? disp_d : '0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      seg_q <= ACTIVE_LOW ? ~DISP_RST : DISP_RST;
    end else begin
      seg_q <= ACTIVE_LOW ? ~seg_raw : seg_raw;
    end
  end

  assign load_ready = ready_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;
  assign seg_out    = seg_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench: a 6-digit and a 4-digit controller share stimulus; each load pushes the
// hand-written expected display per instance, and a monitor compares on every load_ready rise.
module tb_seg_display_ctrl;

  localparam int DW = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic        load_signed = 1'b0;
  logic        mode = 1'b0;
  logic        blank_lz = 1'b0;
  logic        blink_en = 1'b0;

  logic        ready6, busy6, ovf6, ready4, busy4, ovf4;
  logic [47:0] seg6;
  logic [31:0] seg4;

  always #5 clk = ~clk;

  seg_display_ctrl #(.NUM_DIGITS(6), .DATA_W(16), .BLINK_DIV(4), .ACTIVE_LOW(1'b1)) u_dut6 (
    .Clk(clk), .Reset_n(rst_n), .load_valid(load_valid), .load_ready(ready6),
    .load_data(load_data), .load_signed(load_signed), .mode(mode), .blank_lz(blank_lz),
    .blink_en(blink_en), .seg_out(seg6), .busy(busy6), .overflow(ovf6)
  );

  seg_display_ctrl #(.NUM_DIGITS(4), .DATA_W(16), .BLINK_DIV(4), .ACTIVE_LOW(1'b1)) u_dut4 (
    .Clk(clk), .Reset_n(rst_n), .load_valid(load_valid), .load_ready(ready4),
    .load_data(load_data), .load_signed(load_signed), .mode(mode), .blank_lz(blank_lz),
    .blink_en(blink_en), .seg_out(seg4), .busy(busy4), .overflow(ovf4)
  );

  typedef struct {
    logic [47:0] seg;
    logic        ovf;
    int          hs;
    int          lat;
    string       name;
  } exp_t;

  exp_t q6[$];
  exp_t q4[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endfunction

  // Active-low digit pattern for an n-character string, leftmost char = digit n-1.
  function automatic logic [47:0] disp(input string s, input int n);
    logic [47:0] r;
    logic [6:0]  g;
    byte         c;
    r = '0;
    for (int i = 0; i < n; i++) begin
      c = s[n-1-i];
      case (c)
        "0": g = 7'h3F;  "1": g = 7'h06;  "2": g = 7'h5B;  "3": g = 7'h4F;
        "4": g = 7'h66;  "5": g = 7'h6D;  "6": g = 7'h7D;  "7": g = 7'h07;
        "8": g = 7'h7F;  "9": g = 7'h6F;  "A": g = 7'h77;  "B": g = 7'h7C;
        "C": g = 7'h39;  "D": g = 7'h5E;  "E": g = 7'h79;  "F": g = 7'h71;
        "-": g = 7'h40;
        default: g = 7'h00;
      endcase
      r[8*i +: 8] = ~{1'b0, g};
    end
    return r;
  endfunction

  function automatic logic [47:0] offv(input int n);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic void check_out(input string tag, input exp_t e, input logic [47:0] seg,
                                    input logic ovf, input logic bsy);
    chk({tag, " ", e.name, " seg_out"}, 64'(seg), 64'(e.seg));
    chk({tag, " ", e.name, " overflow"}, 64'(ovf), 64'(e.ovf));
    chk({tag, " ", e.name, " latency"}, 64'(cyc - e.hs), 64'(e.lat));
    chk({tag, " ", e.name, " busy"}, 64'(bsy), 64'(0));
  endfunction

  // Monitor: every load_ready rise outside reset is one committed result.
  initial begin
    logic prev6, prev4;
    exp_t e;
    prev6 = 1'b1;
    prev4 = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && ready6 && !prev6) begin
        if (q6.size() == 0) begin
          n_checks++;
          $display("FAIL dut6 unexpected output: seg %h with no pending load", seg6);
        end else begin
          e = q6.pop_front();
          check_out("dut6", e, seg6, ovf6, busy6);
        end
      end
      if (rst_n && ready4 && !prev4) begin
        if (q4.size() == 0) begin
          n_checks++;
          $display("FAIL dut4 unexpected output: seg %h with no pending load", seg4);
        end else begin
          e = q4.pop_front();
          check_out("dut4", e, {16'h0, seg4}, ovf4, busy4);
        end
      end
      prev6 = rst_n ? ready6 : 1'b1;
      prev4 = rst_n ? ready4 : 1'b1;
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(ready6 && ready4) && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (ready6 && ready4) n_pass++;
    else $display("FAIL %s timeout: ready6 %b ready4 %b after %0d cycles, required 1 1",
                  name, ready6, ready4, n);
  endtask

  task automatic push_exp(input string name, input logic md, input string e6, input string e4,
                          input logic o6, input logic o4);
    exp_t e;
    e.name = name;
    e.hs   = cyc + 1;
    e.lat  = md ? DW + 1 : 1;
    e.seg  = disp(e6, 6);
    e.ovf  = o6;
    q6.push_back(e);
    e.seg  = disp(e4, 4);
    e.ovf  = o4;
    q4.push_back(e);
  endtask

  task automatic load(input string name, input logic md, input logic sg, input logic blz,
                      input logic [15:0] d, input string e6, input string e4,
                      input logic o6, input logic o4);
    @(negedge clk);
    #1;
    mode = md; load_signed = sg; blank_lz = blz; load_data = d; load_valid = 1'b1;
    push_exp(name, md, e6, e4, o6, o4);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    wait_idle(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [47:0] on6, on4;
    logic        off_phase;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset seg6", 64'(seg6), 64'(disp("     0", 6)));
    chk("reset seg4", 64'(seg4), 64'(disp("   0", 4)));
    chk("reset ready6", 64'(ready6), 64'(1));
    chk("reset busy6", 64'(busy6), 64'(0));
    chk("reset ovf6", 64'(ovf6), 64'(0));

    load("hex BEEF", 1'b0, 1'b0, 1'b0, 16'hBEEF, "  BEEF", "BEEF", 1'b0, 1'b0);

    // Blink with BLINK_DIV=4: on through edge 3, off edges 4..7, on 8..11, off from 12.
    on6 = disp("  BEEF", 6);
    on4 = disp("BEEF", 4);
    @(negedge clk);
    #1 blink_en = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      off_phase = ((n / 4) % 2) == 1;
      chk($sformatf("blink6 edge %0d", n), 64'(seg6), 64'(off_phase ? offv(6) : on6));
      chk($sformatf("blink4 edge %0d", n), 64'(seg4), 64'(off_phase ? offv(4) : on4));
    end
    #1 blink_en = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      chk($sformatf("blink off6 edge %0d", n), 64'(seg6), 64'(on6));
    end

    load("dec 65535", 1'b1, 1'b0, 1'b1, 16'd65535, " 65535", "----", 1'b0, 1'b1);
    load("dec -32768", 1'b1, 1'b1, 1'b1, 16'h8000, "-32768", "----", 1'b0, 1'b1);
    load("dec -10 lz", 1'b1, 1'b1, 1'b1, 16'hFFF6, "   -10", " -10", 1'b0, 1'b0);
    load("dec -10 nolz", 1'b1, 1'b1, 1'b0, 16'hFFF6, "-00010", "-010", 1'b0, 1'b0);
    load("dec -1000 nolz", 1'b1, 1'b1, 1'b0, 16'hFC18, "-01000", "----", 1'b0, 1'b1);
    load("dec -999 lz", 1'b1, 1'b1, 1'b1, 16'hFC19, "  -999", "-999", 1'b0, 1'b0);
    load("dec signed 9999", 1'b1, 1'b1, 1'b1, 16'd9999, "  9999", "9999", 1'b0, 1'b0);
    load("dec 12345", 1'b1, 1'b0, 1'b1, 16'd12345, " 12345", "----", 1'b0, 1'b1);
    load("dec 7", 1'b1, 1'b0, 1'b1, 16'd7, "     7", "   7", 1'b0, 1'b0);
    load("hex A0 lz", 1'b0, 1'b0, 1'b1, 16'h00A0, "    A0", "  A0", 1'b0, 1'b0);
    load("hex 0 lz", 1'b0, 1'b0, 1'b1, 16'h0000, "     0", "   0", 1'b0, 1'b0);
    load("dec 0 nolz", 1'b1, 1'b0, 1'b0, 16'h0000, "000000", "0000", 1'b0, 1'b0);
    load("hex 8000 signed", 1'b0, 1'b1, 1'b0, 16'h8000, "  8000", "8000", 1'b0, 1'b0);

    // load_valid held through CONV with new data: only the first value may be taken.
    @(negedge clk);
    #1;
    mode = 1'b1; load_signed = 1'b0; blank_lz = 1'b1; load_data = 16'd123; load_valid = 1'b1;
    push_exp("dec 123 held", 1'b1, "   123", " 123", 1'b0, 1'b0);
    @(posedge clk);
    #1 load_data = 16'd456;
    repeat (10) @(posedge clk);
    #1 load_valid = 1'b0;
    wait_idle("dec 123 held");

    // Leave dut4 in overflow, then abort a conversion with reset.
    load("dec 65535 again", 1'b1, 1'b0, 1'b1, 16'd65535, " 65535", "----", 1'b0, 1'b1);
    @(negedge clk);
    #1;
    mode = 1'b1; load_signed = 1'b0; blank_lz = 1'b1; load_data = 16'd999; load_valid = 1'b1;
    @(posedge clk);
    #1 load_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid-conv reset ready6", 64'(ready6), 64'(1));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post reset seg6", 64'(seg6), 64'(disp("     0", 6)));
    chk("post reset seg4", 64'(seg4), 64'(disp("   0", 4)));
    chk("post reset ready4", 64'(ready4), 64'(1));
    chk("post reset busy4", 64'(busy4), 64'(0));
    chk("post reset ovf4", 64'(ovf4), 64'(0));

    load("hex 1234", 1'b0, 1'b0, 1'b0, 16'h1234, "  1234", "1234", 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("dut6 pending results", 64'(q6.size()), 64'(0));
    chk("dut4 pending results", 64'(q4.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
